countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//  Loadable 16-bit down-counter/timer; the decrementing counterpart of the increment datapath.
//  Counts a loaded value down to zero at a prescaled rate, pulses done at zero, optional auto-reload.
//  Sits beside the PC/increment logic as the system timer and loop counter.
// PARAMETERS
//  WIDTH     16  counter/load width in bits
//  PRESCALE  1   clock cycles per decrement while running (>=1); 1 = decrement every cycle
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  load       in   1      load load_val into count and reload register
//  load_val   in   WIDTH  value to load
//  start      in   1      begin counting (honoured in IDLE only)
//  pause      in   1      level; freezes count and prescaler while high in RUN
//  stop       in   1      abort to IDLE, count holds
//  reload_en  in   1      on zero, reload from reload register and keep running
//  count      out  WIDTH  current counter value (registered)
//  busy       out  1      high in RUN or HOLD
//  done       out  1      one-cycle pulse when count reaches zero
// BEHAVIOUR
//  Reset (rst_n low, asynchronous): state=IDLE, count=0, reload reg=0, prescaler=0, busy=0, done=0.
//  Decrement: count_next = count - 1, modulo 2^WIDTH. It is built as ~inc(~count), reusing the
//   half-adder increment chain. The result is bit-identical to count-1.
//  States: IDLE, RUN, HOLD. Priority per cycle: stop > load > pause > start.
//  IDLE: load -> count and reload reg <= load_val next edge.
//   start with count!=0 -> RUN, prescaler=0.
//   start with count==0 -> stay IDLE, done pulses next cycle.
//   load+start in the same cycle -> load wins, start ignored.
//  RUN: prescaler counts 0..PRESCALE-1; count decrements on the edge where prescaler==PRESCALE-1,
//   then the prescaler wraps to 0. First decrement occurs PRESCALE edges after entering RUN.
//  Zero: on the edge where count goes 1->0:
//   done=1 for exactly the following cycle (count==0 visible the same cycle).
//   reload_en=0 -> IDLE, count stays 0.
//   reload_en=1 -> count <= reload reg on the NEXT decrement slot (0 is held one full prescale period),
//    state stays RUN.
//   reload_en=1 with reload reg==0 -> IDLE after the done pulse; the timer must not spin.
//  pause high in RUN -> HOLD: count and prescaler frozen. pause low -> back to RUN, continuing the
//   prescale phase. No decrement is lost or duplicated.
//  load in RUN/HOLD: count and reload reg <= load_val, prescaler=0, state unchanged.
//   load_val==0 in RUN -> done pulse next cycle, then IDLE.
//  stop in RUN/HOLD: -> IDLE next edge, count holds its value, prescaler=0, no done pulse.
//   A stop on the same edge as the 1->0 transition suppresses the decrement and done.
//  busy is registered, high exactly while state is RUN or HOLD.
//  count never underflows past 0: no wrap to 16'hFFFF in any state.
//  Reset mid-count: immediately returns all outputs to reset values; the reload reg is cleared.
// TESTING
//  1 load 16'h0003, start, PRESCALE=1 -> count 3,2,1,0 on successive edges;
//    done high one cycle with count=0; busy falls; count stays 0.
//  2 PRESCALE=4, load 16'h0002, start -> count changes every 4th edge; done 8 edges after start.
//  3 reload_en=1, load 16'h0002, start, 3 periods -> count 2,1,0,2,1,0,...;
//    done once per wrap; busy stays high.
//  4 pause asserted 5 cycles mid-count at count=16'h8000 -> count holds 8000;
//    resumes 7FFF at the correct prescale phase (exercises the full borrow chain).
//  5 start with count 0 -> done pulse, busy never rises;
//    stop at count=1 on the decrement edge -> count stays 1, no done, IDLE.
//  6 rst_n low mid-RUN (count=16'h00FF) -> count=0, busy=0, done=0 asynchronously;
//    after release, start alone does nothing but pulse done.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with prescaler, done pulse and optional auto-reload.
// The decrement is formed as ~inc(~count) so it shares the half-adder increment chain.
module countdown_timer #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic             reload_en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  reload_q, reload_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  count_dec_c;

    // Ripple half-adder increment chain.
    function automatic logic [WIDTH-1:0] inc(input logic [WIDTH-1:0] a);
        logic             c;
        logic [WIDTH-1:0] s;
        c = 1'b1;
        s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = a[i] ^ c;
            c    = a[i] & c;
        end
        return s;
    endfunction

    // count - 1 via the increment chain on inverted operands.
    assign count_dec_c = ~inc(~count_q);

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            presc_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic; priority stop > load > pause > start.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        done_d   = 1'b0;

        if (stop) begin
            state_d = IDLE;
            presc_d = '0;
        end else if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            presc_d  = '0;
            if (state_q != IDLE && load_val == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (count_q == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = RUN;
                            presc_d = '0;
                        end
                    end
                end
                RUN, HOLD: begin
                    if (pause) begin
                        state_d = HOLD;
                    end else begin
                        state_d = RUN;
                        if (presc_q != PS_LAST) begin
                            presc_d = presc_q + PW'(1);
                        end else begin
                            presc_d = '0;
                            if (count_q == WIDTH'(1)) begin
                                count_d = '0;
                                done_d  = 1'b1;
                                if (!reload_en || reload_q == '0) begin
                                    state_d = IDLE;
                                end
                            end else if (count_q == '0) begin
                                // Zero has been held one full period; reload or retire.
                                if (reload_en && reload_q != '0) begin
                                    count_d = reload_q;
                                end else begin
                                    state_d = IDLE;
                                end
                            end else begin
                                count_d = count_dec_c;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    presc_d = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer: two instances (PRESCALE 1 and 4) driven in parallel and
// compared against a cycle-level behavioural model of the timer rules.
module tb_countdown_timer;

    localparam int unsigned W = 16;

    logic          clk;
    logic          rst_n;
    logic          ld, st, pa, sp, re;
    logic [W-1:0]  lv;
    logic [W-1:0]  cnt_a, cnt_b;
    logic          busy_a, busy_b, done_a, done_b;

    int checks;
    int errors;

    countdown_timer #(.WIDTH(W), .PRESCALE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .load(ld), .load_val(lv), .start(st), .pause(pa),
        .stop(sp), .reload_en(re), .count(cnt_a), .busy(busy_a), .done(done_a)
    );

    countdown_timer #(.WIDTH(W), .PRESCALE(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .load(ld), .load_val(lv), .start(st), .pause(pa),
        .stop(sp), .reload_en(re), .count(cnt_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: running flag, value, reload value, cycles into current period.
    typedef struct {
        bit          run;
        int unsigned cnt;
        int unsigned rld;
        int unsigned ph;
        bit          done;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mreset();
        mdl_t m;
        m.run = 0; m.cnt = 0; m.rld = 0; m.ph = 0; m.done = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input int unsigned ps, input bit l,
                                   input int unsigned v, input bit s, input bit p,
                                   input bit stp, input bit r);
        mdl_t n;
        n = m;
        n.done = 0;
        if (stp) begin
            n.run = 0;
            n.ph  = 0;
        end else if (l) begin
            n.cnt = v;
            n.rld = v;
            n.ph  = 0;
            if (m.run && v == 0) begin
                n.run  = 0;
                n.done = 1;
            end
        end else if (!m.run) begin
            if (s) begin
                if (m.cnt == 0) n.done = 1;
                else begin
                    n.run = 1;
                    n.ph  = 0;
                end
            end
        end else if (!p) begin
            if (m.ph + 1 < ps) begin
                n.ph = m.ph + 1;
            end else begin
                n.ph = 0;
                if (m.cnt > 1) begin
                    n.cnt = m.cnt - 1;
                end else if (m.cnt == 1) begin
                    n.cnt  = 0;
                    n.done = 1;
                    if (!(r && m.rld != 0)) n.run = 0;
                end else begin
                    if (r && m.rld != 0) n.cnt = m.rld;
                    else n.run = 0;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [W+1:0] mexp(input mdl_t m);
        return {W'(m.cnt), m.run, m.done};
    endfunction

    // One clock: models advance on the rising edge, outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        if (!rst_n) begin
            ma = mreset();
            mb = mreset();
        end else begin
            ma = mstep(ma, 1, ld, lv, st, pa, sp, re);
            mb = mstep(mb, 4, ld, lv, st, pa, sp, re);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ld = 0; lv = '0; st = 0; pa = 0; sp = 0;
    endtask

    task automatic stop_all();
        idle_inputs();
        sp = 1;
        cyc();
        sp = 0;
    endtask

    task automatic test_reset();
        logic [W+1:0] got;
        #1;
        got = {cnt_a, busy_a, done_a};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_a got=%h exp=0", got);
        end
        got = {cnt_b, busy_b, done_b};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_b got=%h exp=0", got);
        end
        cyc();
        rst_n = 1;
        cyc();
        got = {cnt_a, busy_a, done_a};
        checks++;
        if (got !== mexp(ma)) begin
            errors++;
            $display("FAIL reset_idle_a got=%h exp=%h", got, mexp(ma));
        end
    endtask

    task automatic test_count_basic();
        int unsigned ec[5] = '{3, 2, 1, 0, 0};
        bit          eb[5] = '{1, 1, 1, 0, 0};
        bit          ed[5] = '{0, 0, 0, 1, 0};
        logic [W+1:0] got, exp;
        idle_inputs();
        ld = 1; lv = 16'h0003;
        cyc();
        ld = 0; st = 1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            st = 0;
            got = {cnt_a, busy_a, done_a};
            exp = {W'(ec[k]), eb[k], ed[k]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic_a k=%0d got=%h exp=%h", k, got, exp);
            end
            got = {cnt_b, busy_b, done_b};
            checks++;
            if (got !== mexp(mb)) begin
                errors++;
                $display("FAIL basic_b k=%0d got=%h exp=%h", k, got, mexp(mb));
            end
        end
        stop_all();
    endtask

    task automatic test_prescale();
        logic [W+1:0] got, exp;
        int unsigned  c;
        idle_inputs();
        ld = 1; lv = 16'h0002;
        cyc();
        ld = 0; st = 1;
        cyc();
        st = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            c   = (k < 4) ? 2 : (k < 8) ? 1 : 0;
            exp = {W'(c), (k < 8) ? 1'b1 : 1'b0, (k == 8) ? 1'b1 : 1'b0};
            got = {cnt_b, busy_b, done_b};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL prescale_b k=%0d got=%h exp=%h", k, got, exp);
            end
            got = {cnt_a, busy_a, done_a};
            checks++;
            if (got !== mexp(ma)) begin
                errors++;
                $display("FAIL prescale_a k=%0d got=%h exp=%h", k, got, mexp(ma));
            end
        end
        stop_all();
    endtask

    task automatic test_reload();
        logic [W+1:0] got, exp;
        int unsigned  c;
        idle_inputs();
        re = 1;
        ld = 1; lv = 16'h0002;
        cyc();
        ld = 0; st = 1;
        for (int k = 0; k <= 9; k++) begin
            cyc();
            st  = 0;
            c   = (k % 3 == 0) ? 2 : (k % 3 == 1) ? 1 : 0;
            exp = {W'(c), 1'b1, (k % 3 == 2) ? 1'b1 : 1'b0};
            got = {cnt_a, busy_a, done_a};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reload_a k=%0d got=%h exp=%h", k, got, exp);
            end
            got = {cnt_b, busy_b, done_b};
            checks++;
            if (got !== mexp(mb)) begin
                errors++;
                $display("FAIL reload_b k=%0d got=%h exp=%h", k, got, mexp(mb));
            end
        end
        stop_all();
        re = 0;
    endtask

    task automatic test_pause();
        logic [W+1:0] got, exp;
        idle_inputs();
        ld = 1; lv = 16'h8001;
        cyc();
        ld = 0; st = 1;
        cyc();
        st = 0;
        for (int k = 0; k < 11; k++) begin
            pa = (k >= 1 && k <= 5);
            cyc();
            if (k == 0) exp = {16'h8000, 1'b1, 1'b0};
            else if (k <= 5) exp = {16'h8000, 1'b1, 1'b0};
            else exp = {W'(32'h8000 - (k - 5)), 1'b1, 1'b0};
            got = {cnt_a, busy_a, done_a};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pause_a k=%0d got=%h exp=%h", k, got, exp);
            end
            got = {cnt_b, busy_b, done_b};
            checks++;
            if (got !== mexp(mb)) begin
                errors++;
                $display("FAIL pause_b k=%0d got=%h exp=%h", k, got, mexp(mb));
            end
        end
        stop_all();
    endtask

    task automatic test_zero_stop();
        logic [W+1:0] got, exp;
        logic [W+1:0] ea[5];
        ea[0] = {16'h0000, 1'b0, 1'b1};
        ea[1] = {16'h0000, 1'b0, 1'b0};
        ea[2] = {16'h0002, 1'b1, 1'b0};
        ea[3] = {16'h0001, 1'b1, 1'b0};
        ea[4] = {16'h0001, 1'b0, 1'b0};
        idle_inputs();
        ld = 1; lv = '0;
        cyc();
        ld = 0;
        for (int k = 0; k < 6; k++) begin
            st = (k == 0 || k == 3);
            ld = (k == 2);
            lv = (k == 2) ? 16'h0002 : '0;
            sp = (k == 5);
            cyc();
            if (k == 2) continue;
            exp = (k < 2) ? ea[k] : (k == 5) ? ea[4] : ea[k - 1];
            got = {cnt_a, busy_a, done_a};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL zero_stop_a k=%0d got=%h exp=%h", k, got, exp);
            end
            got = {cnt_b, busy_b, done_b};
            checks++;
            if (got !== mexp(mb)) begin
                errors++;
                $display("FAIL zero_stop_b k=%0d got=%h exp=%h", k, got, mexp(mb));
            end
        end
        stop_all();
        cyc();
        got = {cnt_a, busy_a, done_a};
        checks++;
        if (got !== ea[4]) begin
            errors++;
            $display("FAIL stop_hold_a got=%h exp=%h", got, ea[4]);
        end
    endtask

    task automatic test_reset_mid();
        logic [W+1:0] got;
        idle_inputs();
        ld = 1; lv = 16'h0100;
        cyc();
        ld = 0; st = 1;
        cyc();
        st = 0;
        cyc();
        got = {cnt_a, busy_a, done_a};
        checks++;
        if (got !== {16'h00FF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL pre_reset_a got=%h exp=%h", got, {16'h00FF, 1'b1, 1'b0});
        end
        #2 rst_n = 0;
        #1;
        got = {cnt_a, busy_a, done_a, cnt_b, busy_b, done_b};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL async_reset got=%h exp=0", got);
        end
        cyc();
        rst_n = 1;
        st = 1;
        cyc();
        st = 0;
        got = {cnt_a, busy_a, done_a};
        checks++;
        if (got !== {16'h0000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL post_reset_start_a got=%h exp=%h", got, {16'h0000, 1'b0, 1'b1});
        end
        got = {cnt_b, busy_b, done_b};
        checks++;
        if (got !== mexp(mb)) begin
            errors++;
            $display("FAIL post_reset_start_b got=%h exp=%h", got, mexp(mb));
        end
        cyc();
        got = {cnt_a, busy_a, done_a};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL post_reset_idle_a got=%h exp=0", got);
        end
    endtask

    task automatic test_random();
        logic [W+1:0] got;
        for (int n = 0; n < 3000; n++) begin
            ld = ($urandom_range(0, 15) == 0);
            lv = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
            st = ($urandom_range(0, 3) == 0);
            pa = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 47) == 0);
            if ($urandom_range(0, 15) == 0) re = ~re;
            rst_n = ($urandom_range(0, 499) != 0);
            cyc();
            got = {cnt_a, busy_a, done_a};
            checks++;
            if (got !== mexp(ma)) begin
                errors++;
                $display("FAIL random_a n=%0d got=%h exp=%h", n, got, mexp(ma));
            end
            got = {cnt_b, busy_b, done_b};
            checks++;
            if (got !== mexp(mb)) begin
                errors++;
                $display("FAIL random_b n=%0d got=%h exp=%h", n, got, mexp(mb));
            end
        end
        rst_n = 1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 0;
        re     = 0;
        idle_inputs();
        ma = mreset();
        mb = mreset();
        test_reset();
        test_count_basic();
        test_prescale();
        test_reload();
        test_pause();
        test_zero_stop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
